// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
// Module   : inst_cache
// Purpose  : Direct-mapped read-only instruction cache with 128-bit line refill.
// Revision : 1.0
// ============================================================================
module inst_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         if_re,
  input  logic [31:0]  if_addr,
  output logic [31:0]  if_inst,
  output logic         if_valid,
  output logic         mc_re,
  output logic [31:0]  mc_addr,
  input  logic [127:0] mc_data,
  input  logic         mc_busy
);

  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 drop_q, drop_d;
  logic [27:0]          line_q, line_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [127:0]         data_q [LINES];

  logic [1:0]            word_sel;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic                  hit;
  logic                  fill_we;
  logic [127:0]          rd_line;
  logic                  unused_addr_lsbs;

  assign word_sel         = if_addr[3:2];
  assign idx              = if_addr[4 +: INDEX_BITS];
  assign tag              = if_addr[31 -: TAG_BITS];
  assign fill_idx         = line_q[INDEX_BITS-1:0];
  assign unused_addr_lsbs = ^if_addr[1:0];

  assign rd_line  = data_q[idx];
  assign hit      = if_re & valid_q[idx] & (tag_q[idx] == tag);
  assign if_valid = rdy & (state_q == S_IDLE) & hit;
  assign if_inst  = if_valid ? rd_line[{word_sel, 5'b0} +: 32] : 32'd0;
  assign mc_re    = (state_q != S_IDLE);
  assign mc_addr  = {line_q, 4'b0};

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    line_d  = line_q;
    valid_d = valid_q;
    fill_we = 1'b0;
    if (rdy) begin
      case (state_q)
        S_IDLE: begin
          drop_d = 1'b0;
          if (if_re && !hit && !flush) begin
            line_d  = if_addr[31:4];
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (flush) drop_d = 1'b1;
          if (mc_busy) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (flush) drop_d = 1'b1;
          if (!mc_busy) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
            // A flush coinciding with capture also suppresses the install.
            fill_we = !drop_q && !flush;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (fill_we) valid_d[fill_idx] = 1'b1;
      if (flush)   valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
      line_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      line_q  <= line_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= line_q[27:INDEX_BITS];
      data_q[fill_idx] <= mc_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_cache
// Purpose  : Directed self-checking bench for inst_cache.
// Revision : 1.0
// ============================================================================
module tb_inst_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         rdy;
  logic         flush;
  logic         if_re;
  logic [31:0]  if_addr;
  logic [31:0]  if_inst;
  logic         if_valid;
  logic         mc_re;
  logic [31:0]  mc_addr;
  logic [127:0] mc_data;
  logic         mc_busy;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE0 = {32'h0000000C, 32'h00000008, 32'h00000004, 32'h00000000};
  localparam logic [127:0] LINE1 = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
  localparam logic [127:0] LINE2 = {32'h000000B3, 32'h000000B2, 32'h000000B1, 32'h000000B0};

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .if_re    (if_re),
    .if_addr  (if_addr),
    .if_inst  (if_inst),
    .if_valid (if_valid),
    .mc_re    (mc_re),
    .mc_addr  (mc_addr),
    .mc_data  (mc_data),
    .mc_busy  (mc_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered in the miss cycle; returns in the cycle right after capture.
  task automatic refill(input logic [31:0] exp_addr, input logic [127:0] line,
                        input int busy_cycles, input int flush_at);
    @(negedge clk); #1;
    check("req_mc_re", mc_re, 1'b1);
    check("req_mc_addr", mc_addr, exp_addr);
    check("req_if_valid", if_valid, 1'b0);
    for (int i = 0; i < busy_cycles; i++) begin
      @(negedge clk);
      mc_busy = 1'b1;
      flush   = (i == flush_at);
      #1;
      check("busy_mc_re", mc_re, 1'b1);
      check("busy_mc_addr", mc_addr, exp_addr);
    end
    @(negedge clk);
    flush   = 1'b0;
    mc_busy = 1'b0;
    mc_data = line;
    #1;
    check("cap_mc_re", mc_re, 1'b1);
    check("cap_if_valid", if_valid, 1'b0);
    @(negedge clk); #1;
    check("post_mc_re", mc_re, 1'b0);
  endtask

  task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    if_re   = 1'b1;
    if_addr = addr;
    #1;
    check("hit_valid", if_valid, 1'b1);
    check("hit_inst", if_inst, exp);
    check("hit_mc_re", mc_re, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_re = 1'b0;
    if_addr = 32'd0; mc_data = '0; mc_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_mc_re", mc_re, 1'b0);
    check("rst_mc_addr", mc_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss on 0x0
    @(negedge clk);
    if_re = 1'b1; if_addr = 32'h0; #1;
    check("cold_miss_valid", if_valid, 1'b0);
    check("cold_miss_mc_re", mc_re, 1'b0);
    refill(32'h0, LINE0, 3, -1);
    check("fill0_valid", if_valid, 1'b1);
    check("fill0_inst", if_inst, 32'h0);

    fetch_hit(32'h4, 32'h4);
    fetch_hit(32'h8, 32'h8);
    fetch_hit(32'hC, 32'hC);
    fetch_hit(32'hE, 32'hC);

    // Conflict on index 0
    @(negedge clk);
    if_addr = 32'h400; #1;
    check("conf_miss_valid", if_valid, 1'b0);
    refill(32'h400, LINE1, 2, -1);
    check("conf_fill_inst", if_inst, 32'hA0);
    fetch_hit(32'h408, 32'hA2);
    @(negedge clk);
    if_addr = 32'h0; #1;
    check("evicted_valid", if_valid, 1'b0);
    refill(32'h0, LINE0, 1, -1);
    check("refill0_inst", if_inst, 32'h0);
    fetch_hit(32'hC, 32'hC);

    // Flush while waiting on line 0x10
    @(negedge clk);
    if_addr = 32'h10; #1;
    check("l10_miss", if_valid, 1'b0);
    refill(32'h10, LINE2, 3, 1);
    check("l10_dropped", if_valid, 1'b0);
    if_addr = 32'h0; #1;
    check("l0_flushed", if_valid, 1'b0);
    if_re = 1'b0;

    // rdy low across the busy fall
    @(negedge clk);
    if_re = 1'b1; if_addr = 32'h24; #1;
    check("l20_miss", if_valid, 1'b0);
    @(negedge clk); #1;
    check("l20_req", mc_re, 1'b1);
    check("l20_addr", mc_addr, 32'h20);
    @(negedge clk); mc_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rdy = 1'b0;
      if (i == 1) begin mc_busy = 1'b0; mc_data = LINE2; end
      #1;
      check("frz_valid", if_valid, 1'b0);
      check("frz_mc_re", mc_re, 1'b1);
      check("frz_mc_addr", mc_addr, 32'h20);
    end
    @(negedge clk);
    rdy = 1'b1; #1;
    check("frz_no_cap_re", mc_re, 1'b1);
    check("frz_no_cap_valid", if_valid, 1'b0);
    @(negedge clk); #1;
    check("frz_done_re", mc_re, 1'b0);
    check("frz_fill_valid", if_valid, 1'b1);
    check("frz_fill_inst", if_inst, 32'hB1);

    // Restore 0x0, then reset in the middle of a refill
    @(negedge clk);
    if_addr = 32'h0;
    refill(32'h0, LINE0, 2, -1);
    check("pre_rst_hit", if_valid, 1'b1);
    @(negedge clk);
    if_addr = 32'h30;
    @(negedge clk); #1;
    check("rst_req_re", mc_re, 1'b1);
    rst = 1'b1; #1;
    check("rst_async_re", mc_re, 1'b0);
    check("rst_async_valid", if_valid, 1'b0);
    check("rst_async_addr", mc_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    if_addr = 32'h0; #1;
    check("post_rst_miss", if_valid, 1'b0);
    @(negedge clk); #1;
    check("post_rst_req", mc_re, 1'b1);
    if_re = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
